// File: rtl/control_unit_mc.sv
// Registered multi-cycle control unit for the 8-bit CO224 processor: decodes one
// opcode per accepted instruction and sequences data-memory ops against BUSYWAIT.
module control_unit_mc #(
  parameter int OPCODE_W    = 8,
  parameter int ALUOP_W     = 3,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                INSTR_VALID,
  input  logic [OPCODE_W-1:0] OPCODE,
  input  logic                BUSYWAIT,
  output logic                WRITEENABLE,
  output logic [ALUOP_W-1:0]  ALUOP,
  output logic                ALUSRC,
  output logic                NEMUX,
  output logic [1:0]          BRANCH,
  output logic                READ,
  output logic                WRITE,
  output logic                MEMTOREG,
  output logic                STALL,
  output logic                ILLEGAL,
  output logic                FAULT
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MEM  = 2'd2,
    S_TRAP = 2'd3
  } state_t;

  typedef struct packed {
    logic       we;
    logic [2:0] aluop;
    logic       alusrc;
    logic       nemux;
    logic [1:0] branch;
    logic       rd;
    logic       wr;
    logic       m2r;
    logic       ill;
  } ctrl_t;

  // Loads never set we here: their write-back is granted only in the MEM exit cycle.
  function automatic ctrl_t decode(input logic [OPCODE_W-1:0] op);
    ctrl_t               c;
    logic [OPCODE_W-1:0] hi;
    c  = '0;
    hi = op >> 3'd5;
    if (hi != '0) begin
      c.ill = 1'b1;
    end else begin
      case (op[4:0])
        5'h00: begin c.we = 1'b1; c.aluop = 3'b001; c.alusrc = 1'b1; end
        5'h01: begin c.we = 1'b1; c.aluop = 3'b001; c.alusrc = 1'b1; c.nemux = 1'b1; end
        5'h02: begin c.we = 1'b1; c.aluop = 3'b010; c.alusrc = 1'b1; end
        5'h03: begin c.we = 1'b1; c.aluop = 3'b011; c.alusrc = 1'b1; end
        5'h04: begin c.we = 1'b1; c.aluop = 3'b000; c.alusrc = 1'b1; end
        5'h05: begin c.we = 1'b1; c.aluop = 3'b000; c.alusrc = 1'b0; end
        5'h06: begin c.branch = 2'b01; end
        5'h07: begin c.aluop = 3'b001; c.alusrc = 1'b1; c.nemux = 1'b1; c.branch = 2'b10; end
        5'h08: begin c.aluop = 3'b001; c.alusrc = 1'b1; c.nemux = 1'b1; c.branch = 2'b11; end
        5'h09: begin c.we = 1'b1; c.aluop = 3'b100; c.alusrc = 1'b1; end
        5'h0A: begin c.we = 1'b1; c.aluop = 3'b101; c.alusrc = 1'b0; end
        5'h0C: begin c.we = 1'b1; c.aluop = 3'b110; c.alusrc = 1'b0; end
        5'h0D: begin c.we = 1'b1; c.aluop = 3'b111; c.alusrc = 1'b0; end
        5'h0E: begin c.alusrc = 1'b1; c.rd = 1'b1; c.m2r = 1'b1; end
        5'h0F: begin c.alusrc = 1'b0; c.rd = 1'b1; c.m2r = 1'b1; end
        5'h10: begin c.alusrc = 1'b1; c.wr = 1'b1; end
        5'h11: begin c.alusrc = 1'b0; c.wr = 1'b1; end
        default: begin c.ill = 1'b1; end
      endcase
    end
    return c;
  endfunction

  state_t          state_q;
  logic [CNT_W-1:0] cnt_q;
  ctrl_t           ctl_q;
  logic            fault_q;

  ctrl_t dec_d;
  logic  accept_s;
  logic  mem_done_s;
  logic  timeout_s;
  logic  stall_s;

  // Accept/stall decisions from current state, wait counter and BUSYWAIT.
  always_comb begin
    dec_d      = decode(OPCODE);
    accept_s   = 1'b0;
    mem_done_s = 1'b0;
    timeout_s  = 1'b0;
    stall_s    = 1'b0;
    case (state_q)
      S_IDLE, S_EXEC: begin
        accept_s = INSTR_VALID;
      end
      S_MEM: begin
        mem_done_s = !BUSYWAIT && (cnt_q != '0);
        timeout_s  = BUSYWAIT && (cnt_q == CNT_MAX);
        stall_s    = !mem_done_s;
        accept_s   = INSTR_VALID && mem_done_s;
      end
      S_TRAP: begin
        stall_s = 1'b1;
      end
      default: begin
        stall_s = 1'b0;
      end
    endcase
  end

  // Sequencer with registered control fields; async reset clears everything at once.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ctl_q   <= '0;
      fault_q <= 1'b0;
    end else if (accept_s) begin
      ctl_q   <= dec_d;
      cnt_q   <= '0;
      state_q <= (dec_d.rd || dec_d.wr) ? S_MEM : S_EXEC;
    end else if (state_q == S_IDLE || state_q == S_EXEC || mem_done_s) begin
      ctl_q   <= '0;
      cnt_q   <= '0;
      state_q <= S_IDLE;
    end else if (timeout_s) begin
      ctl_q   <= '0;
      fault_q <= 1'b1;
      state_q <= S_TRAP;
    end else if (state_q == S_MEM) begin
      if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else begin
      state_q <= state_q;
    end
  end

  assign WRITEENABLE = ctl_q.we | (ctl_q.m2r & mem_done_s);
  assign ALUOP       = ALUOP_W'(ctl_q.aluop);
  assign ALUSRC      = ctl_q.alusrc;
  assign NEMUX       = ctl_q.nemux;
  assign BRANCH      = ctl_q.branch;
  assign READ        = ctl_q.rd;
  assign WRITE       = ctl_q.wr;
  assign MEMTOREG    = ctl_q.m2r;
  assign ILLEGAL     = ctl_q.ill;
  assign FAULT       = fault_q;
  assign STALL       = stall_s;

endmodule

// File: tb/tb_control_unit_mc.sv
// Scoreboard bench for control_unit_mc: stimulus pushes hand-computed per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_control_unit_mc;

  logic       CLK;
  logic       RESET;
  logic       INSTR_VALID;
  logic [7:0] OPCODE;
  logic       BUSYWAIT;
  logic       WRITEENABLE;
  logic [2:0] ALUOP;
  logic       ALUSRC;
  logic       NEMUX;
  logic [1:0] BRANCH;
  logic       READ;
  logic       WRITE;
  logic       MEMTOREG;
  logic       STALL;
  logic       ILLEGAL;
  logic       FAULT;

  control_unit_mc #(.OPCODE_W(8), .ALUOP_W(3), .TIMEOUT_CYC(16)) dut (
    .CLK(CLK), .RESET(RESET), .INSTR_VALID(INSTR_VALID), .OPCODE(OPCODE),
    .BUSYWAIT(BUSYWAIT), .WRITEENABLE(WRITEENABLE), .ALUOP(ALUOP),
    .ALUSRC(ALUSRC), .NEMUX(NEMUX), .BRANCH(BRANCH), .READ(READ),
    .WRITE(WRITE), .MEMTOREG(MEMTOREG), .STALL(STALL), .ILLEGAL(ILLEGAL),
    .FAULT(FAULT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  logic [13:0] exp_q[$];
  string       name_q[$];

  // Vector layout: {FAULT, ILLEGAL, STALL, MEMTOREG, WRITE, READ, BRANCH, NEMUX, ALUSRC, ALUOP, WE}
  function automatic logic [13:0] mk(input logic we, input logic [2:0] alu,
                                     input logic src, input logic neg,
                                     input logic [1:0] br, input logic rd,
                                     input logic wr, input logic m2r,
                                     input logic st, input logic ill,
                                     input logic flt);
    return {flt, ill, st, m2r, wr, rd, br, neg, src, alu, we};
  endfunction

  logic [13:0] Z;
  assign Z = 14'd0;

  // Monitor: compare the DUT outputs at each negedge against the queued expectation.
  always @(negedge CLK) begin
    logic [13:0] got;
    logic [13:0] e;
    string       nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      got = {FAULT, ILLEGAL, STALL, MEMTOREG, WRITE, READ, BRANCH, NEMUX,
             ALUSRC, ALUOP, WRITEENABLE};
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b (F I S M W R BR N S ALU WE)", nm, got, e);
      end
    end
  end

  task automatic step(input logic rst, input logic v, input logic [7:0] op,
                      input logic busy, input logic [13:0] e, input string nm);
    @(posedge CLK);
    #1;
    RESET       = rst;
    INSTR_VALID = v;
    OPCODE      = op;
    BUSYWAIT    = busy;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [13:0] lw_busy, lw_exit, lwi_busy, lwi_exit, trap_v;
    RESET = 1'b0; INSTR_VALID = 1'b0; OPCODE = 8'h00; BUSYWAIT = 1'b0;
    lw_busy  = mk(1'b0, 3'b000, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    lw_exit  = mk(1'b1, 3'b000, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    lwi_busy = mk(1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    lwi_exit = mk(1'b1, 3'b000, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    trap_v   = mk(1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // reset, single add, async reset mid-cycle
    step(1'b0, 1'b1, 8'h00, 1'b0, Z, "reset_hold");
    step(1'b1, 1'b1, 8'h00, 1'b0, Z, "idle_after_reset");
    step(1'b1, 1'b0, 8'h00, 1'b0, mk(1'b1, 3'b001, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "add_decode");
    step(1'b1, 1'b0, 8'h00, 1'b0, Z, "add_then_idle");
    step(1'b1, 1'b1, 8'h00, 1'b0, Z, "add2_issue");
    step(1'b0, 1'b0, 8'h00, 1'b0, Z, "async_reset_clears");
    step(1'b1, 1'b0, 8'h00, 1'b0, Z, "post_reset_idle");

    // back-to-back sub, beq, bne, j, ror
    step(1'b1, 1'b1, 8'h01, 1'b0, Z, "b2b_issue_sub");
    step(1'b1, 1'b1, 8'h07, 1'b0, mk(1'b1, 3'b001, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "b2b_sub");
    step(1'b1, 1'b1, 8'h08, 1'b0, mk(1'b0, 3'b001, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "b2b_beq");
    step(1'b1, 1'b1, 8'h06, 1'b0, mk(1'b0, 3'b001, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "b2b_bne");
    step(1'b1, 1'b1, 8'h0D, 1'b0, mk(1'b0, 3'b000, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "b2b_j");
    step(1'b1, 1'b0, 8'h00, 1'b0, mk(1'b1, 3'b111, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "b2b_ror");
    step(1'b1, 1'b0, 8'h00, 1'b0, Z, "b2b_idle");

    // remaining ALU opcodes back-to-back: mov, loadi, mult, sl, sra
    step(1'b1, 1'b1, 8'h04, 1'b0, Z, "alu_issue_mov");
    step(1'b1, 1'b1, 8'h05, 1'b0, mk(1'b1, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "mov");
    step(1'b1, 1'b1, 8'h09, 1'b0, mk(1'b1, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "loadi");
    step(1'b1, 1'b1, 8'h0A, 1'b0, mk(1'b1, 3'b100, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "mult");
    step(1'b1, 1'b1, 8'h0C, 1'b0, mk(1'b1, 3'b101, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "sl");
    step(1'b1, 1'b0, 8'h00, 1'b0, mk(1'b1, 3'b110, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "sra");
    step(1'b1, 1'b0, 8'h00, 1'b0, Z, "alu_idle");

    // lwd with BUSYWAIT high for 3 cycles; add offered during the stall must be ignored
    step(1'b1, 1'b1, 8'h0E, 1'b0, Z, "lwd_issue");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'h00, 1'b1, lw_busy, "lwd_stall");
    step(1'b1, 1'b0, 8'h00, 1'b0, lw_exit, "lwd_exit");
    step(1'b1, 1'b0, 8'h00, 1'b0, Z, "lwd_done_no_latch");

    // lwi with BUSYWAIT high for 1 cycle: MEM lasts 2 cycles
    step(1'b1, 1'b1, 8'h0F, 1'b0, Z, "lwi_issue");
    step(1'b1, 1'b0, 8'h00, 1'b1, lwi_busy, "lwi_stall");
    step(1'b1, 1'b0, 8'h00, 1'b0, lwi_exit, "lwi_exit");
    step(1'b1, 1'b0, 8'h00, 1'b0, Z, "lwi_idle");

    // swi minimum length
    step(1'b1, 1'b1, 8'h11, 1'b0, Z, "swi_issue");
    step(1'b1, 1'b0, 8'h00, 1'b0, mk(1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), "swi_cnt0");
    step(1'b1, 1'b0, 8'h00, 1'b0, mk(1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "swi_exit");
    step(1'b1, 1'b0, 8'h00, 1'b0, Z, "swi_idle");

    // swd followed by 'or' accepted in the exit cycle
    step(1'b1, 1'b1, 8'h10, 1'b0, Z, "swd_issue");
    step(1'b1, 1'b0, 8'h00, 1'b0, mk(1'b0, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), "swd_cnt0");
    step(1'b1, 1'b1, 8'h03, 1'b0, mk(1'b0, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "swd_exit_issue_or");
    step(1'b1, 1'b0, 8'h00, 1'b0, mk(1'b1, 3'b011, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "or_after_mem");
    step(1'b1, 1'b0, 8'h00, 1'b0, Z, "or_idle");

    // illegal opcodes 0x0B, 0x1F, 0x80, 0x12, then a legal 'and'
    step(1'b1, 1'b1, 8'h0B, 1'b0, Z, "ill_issue_0b");
    step(1'b1, 1'b1, 8'h1F, 1'b0, mk(1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "ill_0b");
    step(1'b1, 1'b1, 8'h80, 1'b0, mk(1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "ill_1f");
    step(1'b1, 1'b1, 8'h12, 1'b0, mk(1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "ill_80");
    step(1'b1, 1'b1, 8'h02, 1'b0, mk(1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "ill_12");
    step(1'b1, 1'b0, 8'h00, 1'b0, mk(1'b1, 3'b010, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "and_after_ill");
    step(1'b1, 1'b0, 8'h00, 1'b0, Z, "ill_idle");

    // lwd timeout: 17 MEM cycles with BUSYWAIT stuck high, then sticky TRAP
    step(1'b1, 1'b1, 8'h0E, 1'b1, Z, "to_issue");
    for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 8'h00, 1'b1, lw_busy, "to_mem_wait");
    step(1'b1, 1'b1, 8'h00, 1'b1, trap_v, "trap_enter");
    step(1'b1, 1'b1, 8'h01, 1'b0, trap_v, "trap_ignore_valid");
    step(1'b1, 1'b1, 8'h0E, 1'b0, trap_v, "trap_sticky");
    step(1'b0, 1'b0, 8'h00, 1'b0, Z, "trap_reset_clears");
    step(1'b1, 1'b1, 8'h00, 1'b0, Z, "recover_issue_add");
    step(1'b1, 1'b0, 8'h00, 1'b0, mk(1'b1, 3'b001, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "recover_add");

    // let the monitor drain, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
